// File: rtl/i2c_target_burst.sv
// I2C target with parametrised address/data widths, burst auto-increment and register-bus handshake.
// Optional SCL clock stretching on late read data: define I2C_TARGET_CLK_STRETCH_EN.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   dev_id              7-bit device address
//   scl_i, sda_i        bus pin levels
//   sda_oe, scl_oe      open-drain pull-down enables
//   reg_addr            current word address (auto-increments per word)
//   reg_wdata, reg_wr   assembled write word and one-cycle write strobe
//   reg_rd              one-cycle read request
//   reg_rdata, reg_rvalid  read return data and its valid
//   busy, rd_err        START..STOP flag, sticky late-read-data flag

module i2c_target_burst #(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              dev_id,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  output logic                    scl_oe,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    reg_rvalid,
  output logic                    busy,
  output logic                    rd_err
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK,
    RD_FETCH, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sy;
  logic [SYNC_STAGES-1:0] sda_sy;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start;
  logic                   stop;
  logic [3:0]             bit_cnt;
  logic [1:0]             byte_cnt;
  logic [6:0]             sh;
  logic                   ack_drv;
  logic                   fetch_ack;
  logic                   have_data;
  logic                   fetch_ok;
  logic [DATA_W-1:0]      fetch_word;
  logic [DATA_W-1:0]      rd_sh;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic                   stretching;
`else
  assign scl_oe = 1'b0;
`endif

  assign scl_s    = scl_sy[SYNC_STAGES-1];
  assign sda_s    = sda_sy[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

  // Data may land in the same cycle as the first-bit falling edge.
  assign fetch_ok   = have_data | reg_rvalid;
  assign fetch_word = have_data ? rd_sh : reg_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scl_sy    <= '1;
      sda_sy    <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sh        <= '0;
      ack_drv   <= 1'b0;
      fetch_ack <= 1'b0;
      have_data <= 1'b0;
      rd_sh     <= '0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      rd_err    <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe     <= 1'b0;
      stretching <= 1'b0;
`endif
    end else begin
      scl_sy <= {scl_sy[SYNC_STAGES-2:0], scl_i};
      sda_sy <= {sda_sy[SYNC_STAGES-2:0], sda_i};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      // Address advances while the strobe is high, so it is stable during it.
      if (reg_wr)
        reg_addr <= reg_addr + ADDR_W'(1);
      if (stop) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_drv <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_oe     <= 1'b0;
        stretching <= 1'b0;
`endif
      end else if (start) begin
        state    <= DEV;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        busy     <= 1'b1;
        sda_oe   <= 1'b0;
        rd_err   <= 1'b0;
        ack_drv  <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_oe     <= 1'b0;
        stretching <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: ;
          DEV: if (scl_rise) begin
            sh      <= {sh[5:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              ack_drv <= 1'b0;
              if (sh != dev_id)
                state <= WAIT_STOP;
              else if (sda_s) begin
                // Read: fetch during the ACK clock; RD_FETCH drives the ACK.
                state     <= RD_FETCH;
                reg_rd    <= 1'b1;
                fetch_ack <= 1'b1;
                have_data <= 1'b0;
              end else
                state <= DEV_ACK;
            end
          end
          DEV_ACK: if (scl_fall) begin
            sda_oe  <= ~ack_drv;
            ack_drv <= ~ack_drv;
            if (ack_drv) begin
              state    <= ADDR;
              byte_cnt <= '0;
            end
          end
          ADDR: if (scl_rise) begin
            reg_addr <= {reg_addr[ADDR_W-2:0], sda_s};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= ADDR_ACK;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            sda_oe  <= ~ack_drv;
            ack_drv <= ~ack_drv;
            if (ack_drv) begin
              if (byte_cnt == A_LAST) begin
                state    <= WDATA;
                byte_cnt <= '0;
              end else begin
                state    <= ADDR;
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end
          WDATA: if (scl_rise) begin
            reg_wdata <= {reg_wdata[DATA_W-2:0], sda_s};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= WDATA_ACK;
              if (byte_cnt == D_LAST) begin
                reg_wr   <= 1'b1;
                byte_cnt <= '0;
              end else
                byte_cnt <= byte_cnt + 2'd1;
            end
          end
          WDATA_ACK: if (scl_fall) begin
            sda_oe  <= ~ack_drv;
            ack_drv <= ~ack_drv;
            if (ack_drv)
              state <= WDATA;
          end
          RD_FETCH: begin
            if (reg_rvalid && !have_data) begin
              rd_sh     <= reg_rdata;
              have_data <= 1'b1;
            end
`ifdef I2C_TARGET_CLK_STRETCH_EN
            if (stretching) begin
              if (reg_rvalid) begin
                stretching <= 1'b0;
                scl_oe     <= 1'b0;
                rd_sh      <= reg_rdata;
                sda_oe     <= ~reg_rdata[DATA_W-1];
                state      <= RDATA;
              end
            end else
`endif
            if (scl_fall) begin
              if (fetch_ack && !ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                ack_drv   <= 1'b0;
                fetch_ack <= 1'b0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                if (fetch_ok) begin
                  rd_sh  <= fetch_word;
                  sda_oe <= ~fetch_word[DATA_W-1];
                  state  <= RDATA;
                end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                  stretching <= 1'b1;
                  scl_oe     <= 1'b1;
                  sda_oe     <= 1'b0;
`else
                  rd_sh  <= '1;
                  sda_oe <= 1'b0;
                  rd_err <= 1'b1;
                  state  <= RDATA;
`endif
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise)
              bit_cnt <= bit_cnt + 4'd1;
            else if (scl_fall) begin
              // bit_cnt==0: first bit of a follow-on byte, nothing consumed yet.
              if (bit_cnt == 4'd0)
                sda_oe <= ~rd_sh[DATA_W-1];
              else if (bit_cnt == 4'd8) begin
                rd_sh   <= {rd_sh[DATA_W-2:0], 1'b1};
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA_ACK;
              end else begin
                rd_sh  <= {rd_sh[DATA_W-2:0], 1'b1};
                sda_oe <= ~rd_sh[DATA_W-2];
              end
            end
          end
          RDATA_ACK: if (scl_rise) begin
            if (sda_s)
              state <= WAIT_STOP;
            else if (byte_cnt == D_LAST) begin
              reg_addr  <= reg_addr + ADDR_W'(1);
              reg_rd    <= 1'b1;
              fetch_ack <= 1'b0;
              ack_drv   <= 1'b0;
              have_data <= 1'b0;
              byte_cnt  <= '0;
              state     <= RD_FETCH;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              bit_cnt  <= '0;
              state    <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_burst.sv
// Directed bench for i2c_target_burst: bit-banged I2C master plus register responder.
// ADDR_BYTES=2, DATA_BYTES=2, dev_id=0x50, SCL at 8 clk per phase.

module tb_i2c_target_burst;

  logic        clk;
  logic        rst;
  logic [6:0]  dev_id;
  logic        scl_m;
  logic        sda_m;
  logic        scl_line;
  logic        sda_line;
  logic        sda_oe;
  logic        scl_oe;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_rvalid;
  logic        busy;
  logic        rd_err;

  int checks;
  int failures;
  int wr_total;
  int rd_total;
  int oe_total;
  int scl_total;
  int rv_lat;
  int rv_cnt;
  logic [15:0] rv_addr;
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_burst #(
    .ADDR_BYTES(2),
    .DATA_BYTES(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dev_id(dev_id),
    .scl_i(scl_line),
    .sda_i(sda_line),
    .sda_oe(sda_oe),
    .scl_oe(scl_oe),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr(reg_wr),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid),
    .busy(busy),
    .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0010: mem = 16'hBEEF;
      16'h0011: mem = 16'hCAFE;
      default:  mem = 16'h5A5A;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      reg_rvalid = 1'b0;
      reg_rdata  = '0;
      rv_cnt     = 0;
      wr_total   = 0;
      rd_total   = 0;
      oe_total   = 0;
      scl_total  = 0;
    end else begin
      reg_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt = rv_cnt - 1;
        if (rv_cnt == 0) begin
          reg_rvalid = 1'b1;
          reg_rdata  = mem(rv_addr);
        end
      end
      if (reg_wr) begin
        wr_total++;
        wa_q.push_back(reg_addr);
        wd_q.push_back(reg_wdata);
      end
      if (reg_rd) begin
        rd_total++;
        rv_cnt  = rv_lat;
        rv_addr = reg_addr;
      end
      if (sda_oe) oe_total++;
      if (scl_oe) scl_total++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_m = 1'b1;
    wclk(1);
    while (scl_line !== 1'b1 && t < 5000) begin
      wclk(1);
      t++;
    end
    if (t >= 5000) check("scl_release", 32'(scl_line), 32'd1);
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    wclk(4);
    scl_high();
    wclk(8);
    sda_m = 1'b0;
    wclk(8);
    scl_m = 1'b0;
    wclk(4);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    wclk(4);
    scl_high();
    wclk(8);
    sda_m = 1'b1;
    wclk(8);
  endtask

  task automatic do_bit(input logic b, output logic s);
    sda_m = b;
    wclk(4);
    scl_high();
    wclk(7);
    s = sda_line;
    wclk(1);
    scl_m = 1'b0;
    wclk(4);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) do_bit(b[i], s);
    do_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, s);
      d[i] = s;
    end
    do_bit(~mack, s);
  endtask

  int          acks;
  int          wb;
  int          rb;
  int          ob;
  int          sb;
  logic        a;
  logic [7:0]  d0, d1, d2, d3;

  task automatic wr_seq(input logic [7:0] b);
    logic k;
    wr_byte(b, k);
    if (k) acks++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rv_lat   = 3;
    dev_id   = 7'h50;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rst      = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(3);
    check("rst_flags", 32'({sda_oe, scl_oe, busy, reg_wr, reg_rd, rd_err}), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);

    // single word write
    wb = wr_total; acks = 0;
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    wr_seq(8'hA0); wr_seq(8'h12); wr_seq(8'h34); wr_seq(8'hAB); wr_seq(8'hCD);
    do_stop();
    wclk(2);
    check("t1_acks", 32'(acks), 32'd5);
    check("t1_nwr", 32'(wr_total - wb), 32'd1);
    check("t1_addr", 32'(wa_q[wb]), 32'h1234);
    check("t1_data", 32'(wd_q[wb]), 32'hABCD);
    check("t1_busy_end", 32'(busy), 32'd0);

    // burst write with address wrap
    wb = wr_total; acks = 0;
    do_start();
    wr_seq(8'hA0); wr_seq(8'hFF); wr_seq(8'hFF);
    wr_seq(8'hAB); wr_seq(8'hCD); wr_seq(8'h11); wr_seq(8'h22);
    do_stop();
    wclk(2);
    check("t2_acks", 32'(acks), 32'd7);
    check("t2_nwr", 32'(wr_total - wb), 32'd2);
    check("t2_addr0", 32'(wa_q[wb]), 32'hFFFF);
    check("t2_data0", 32'(wd_q[wb]), 32'hABCD);
    check("t2_addr1", 32'(wa_q[wb+1]), 32'h0000);
    check("t2_data1", 32'(wd_q[wb+1]), 32'h1122);
    check("t2_addr_end", 32'(reg_addr), 32'h0001);

    // repeated-START burst read
    wb = wr_total; rb = rd_total; acks = 0;
    do_start();
    wr_seq(8'hA0); wr_seq(8'h00); wr_seq(8'h10);
    do_start();
    wr_seq(8'hA1);
    rd_byte(1'b1, d0); rd_byte(1'b1, d1); rd_byte(1'b1, d2); rd_byte(1'b0, d3);
    do_stop();
    wclk(2);
    check("t3_acks", 32'(acks), 32'd4);
    check("t3_data", {d0, d1, d2, d3}, 32'hBEEFCAFE);
    check("t3_nrd", 32'(rd_total - rb), 32'd2);
    check("t3_nwr", 32'(wr_total - wb), 32'd0);
    check("t3_rd_err", 32'(rd_err), 32'd0);

    // ID mismatch
    wb = wr_total; rb = rd_total; ob = oe_total;
    do_start();
    wr_byte(8'hA2, a);
    wr_byte(8'h12, a);
    wr_byte(8'h34, a);
    do_stop();
    wclk(2);
    check("t4_ack", 32'(a), 32'd0);
    check("t4_oe", 32'(oe_total - ob), 32'd0);
    check("t4_nwr", 32'(wr_total - wb), 32'd0);
    check("t4_nrd", 32'(rd_total - rb), 32'd0);

    // abort mid-word, then a normal write
    wb = wr_total;
    do_start();
    wr_seq(8'hA0); wr_seq(8'h12); wr_seq(8'h34); wr_seq(8'hAB);
    do_stop();
    wclk(2);
    check("t5_abort_nwr", 32'(wr_total - wb), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    wb = wr_total; acks = 0;
    do_start();
    wr_seq(8'hA0); wr_seq(8'h00); wr_seq(8'h20); wr_seq(8'h55); wr_seq(8'h66);
    do_stop();
    wclk(2);
    check("t5_acks", 32'(acks), 32'd5);
    check("t5_nwr", 32'(wr_total - wb), 32'd1);
    check("t5_addr", 32'(wa_q[wb]), 32'h0020);
    check("t5_data", 32'(wd_q[wb]), 32'h5566);

    // late read data
    rv_lat = 200;
    rb = rd_total; sb = scl_total;
    do_start();
    wr_byte(8'hA0, a); wr_byte(8'h00, a); wr_byte(8'h10, a);
    do_start();
    wr_byte(8'hA1, a);
    check("t6_hdr_ack", 32'(a), 32'd1);
    rd_byte(1'b0, d0);
    do_stop();
    wclk(2);
`ifdef I2C_TARGET_CLK_STRETCH_EN
    check("t6_data", 32'(d0), 32'hBE);
    check("t6_rd_err", 32'(rd_err), 32'd0);
    check("t6_stretched", 32'(scl_total - sb > 100), 32'd1);
`else
    check("t6_data", 32'(d0), 32'hFF);
    check("t6_rd_err", 32'(rd_err), 32'd1);
    check("t6_no_stretch", 32'(scl_total - sb), 32'd0);
`endif
    wclk(300);
    rv_lat = 3;
    check("t6_nrd", 32'(rd_total - rb), 32'd1);
    do_start();
    wclk(4);
    check("t6_err_clr", 32'(rd_err), 32'd0);
    do_stop();
    wclk(4);
    check("t6_scl_idle", 32'(scl_oe), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
